regfile_2r1w: RTL and testbench
===============================

Name: regfile_2r1w

Overview:
- Parametrised register file: DEPTH words of WIDTH bits, one write port, two registered read ports.
- Write select comes from a parametrised one-hot decoder that generalises the fixed 3-to-8 load decoder. Each load line enables exactly one storage word.
- Adds the following over the fixed 8-entry decoder-based file: write enable, optional write-to-read bypass, optional hardwired zero register, and out-of-range address handling.
- Sits between the datapath control unit (addresses, write enable) and the ALU operand/result buses.

Parameters:
- DEPTH, 8, number of storage words (2..64, need not be a power of two).
- WIDTH, 16, bits per word (1..64).
- BYPASS, 1, 1 = read of the address being written in the same cycle returns the new data; 0 = returns the old data.
- ZERO_REG, 0, 1 = word 0 always reads 0 and writes to it are discarded.
- ADDR_W (localparam), ceil(log2(DEPTH)), minimum 1, address width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  WIDTH  write data
- raddr_a  in  ADDR_W  read address, port A
- raddr_b  in  ADDR_W  read address, port B
- rdata_a  out  WIDTH  registered read data, port A
- rdata_b  out  WIDTH  registered read data, port B
- load  out  DEPTH  one-hot write strobe; combinational, for debug/trace

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset:
  - All storage words clear to 0; rdata_a and rdata_b clear to 0.
  - Reset has priority over a simultaneous write, so nothing is stored in that cycle.
- Decode: load = one-hot of waddr, gated by we.
  - load is all-zero when we=0.
  - load is all-zero when waddr >= DEPTH.
  - load bit 0 is forced to 0 when ZERO_REG=1.
  - load is combinational and is not affected by reset.
- Write: on the edge where load[i]=1, word[i] <= wdata. At most one word changes per cycle.
- Read latency is 1 cycle. On edge k, rdata_x <= value(raddr_x sampled at edge k). The value is visible after edge k until edge k+1.
- value(addr) rules:
  - addr >= DEPTH -> 0.
  - ZERO_REG=1 and addr==0 -> 0.
  - BYPASS=1, we=1 and addr==waddr (the write is valid, i.e. its load bit is set) -> wdata.
  - Otherwise -> word[addr] as stored before this edge.
- Port A and port B are independent. Both may address the same word, and both may hit the bypass in the same cycle.
- BYPASS=0 with same-address read and write: the read returns the old word; the new word is visible on the next read.
- Reset deasserting mid-stream: the first edge with reset=0 performs a normal write and read. Reads on that edge return 0, or the bypassed wdata when BYPASS=1.
- Width rules: no arithmetic. wdata is stored unmodified. Upper address bits beyond DEPTH are handled by the out-of-range rule and never wrap.
- No X on outputs after the first reset edge, for any input combination.

Decomposition:
- Shared package regfile_pkg holds:
  - the function computing ADDR_W from DEPTH;
  - the default DEPTH and WIDTH constants used by the datapath.
- Natural sub-module: decode_onehot, parametrised (IN_W, OUT_N, enable input). It is combinational and generalises the 3-to-8 decoder. It is instantiated once for the write path.
- Read muxing and bypass stay inline in regfile_2r1w.

Test Plan:
- Reset, then write: assert reset for 2 cycles with we=1, waddr=3, wdata=16'hFFFF -> rdata_a=rdata_b=0 and all words 0. Then write 16'h1234 to addr 5 and read A=5 one cycle later -> rdata_a=16'h1234 on the following edge; load=8'b0010_0000 during the write cycle.
- Sweep: write word i = 16'hA000+i for i=0..7, then read A=i and B=7-i -> rdata_a=16'hA000+i, rdata_b=16'hA007-i, each 1 cycle after the address.
- Bypass (BYPASS=1): word 2 holds 16'h0011; in one cycle, we=1, waddr=2, wdata=16'h00FF, raddr_a=raddr_b=2 -> both read 16'h00FF next cycle. Same stimulus with BYPASS=0 -> both read 16'h0011, then 16'h00FF on the following read.
- Zero register (ZERO_REG=1): write 16'hBEEF to addr 0 -> load=0; reading addr 0 returns 0, including in the same cycle as the write when BYPASS=1.
- Out of range (DEPTH=6, ADDR_W=3): write 16'h5555 to addr 6 -> load=6'b0, no word changes; reading addr 7 returns 0.
- Width extreme (WIDTH=1, DEPTH=2): alternate writes 1/0 to addr 1 while reading addr 1 on both ports -> data toggles correctly with 1-cycle latency; asserting reset mid-sequence clears the outputs on that edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file.
// Address width helper and datapath default sizes.
package regfile_pkg;

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_WIDTH = 16;

    // Smallest width able to index depth entries, never below 1.
    function automatic int addr_width(input int depth);
        for (int w = 1; w < 31; w++) begin
            if ((1 << w) >= depth) return w;
        end
        return 31;
    endfunction

endpackage

// File: rtl/decode_onehot.sv
// Parametrised one-hot decoder with enable.
// Inputs beyond OUT_N-1 produce an all-zero output.
module decode_onehot #(
    parameter int IN_W  = 3,
    parameter int OUT_N = 8
) (
    input  logic            i_en,
    input  logic [IN_W-1:0] i_addr,
    output logic [OUT_N-1:0] o_onehot
);

    // One output line per code; codes with no line decode to nothing.
    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < OUT_N; i++) begin
            if (i_en && (i_addr == IN_W'(i))) begin
                o_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Register file: one decoded write port, two registered read ports.
// Optional write-to-read bypass and hardwired zero word.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0,
    localparam int ADDR_W  = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b,
    output logic [DEPTH-1:0]  load
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [DEPTH-1:0] ZMASK =
        ZERO_REG ? DEPTH'(1) : '0;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] w_dec;
    logic             w_wr_valid;
    logic [WIDTH-1:0] w_val_a;
    logic [WIDTH-1:0] w_val_b;

    decode_onehot #(
        .IN_W  (ADDR_W),
        .OUT_N (DEPTH)
    ) u_wdec (
        .i_en     (we),
        .i_addr   (waddr),
        .o_onehot (w_dec)
    );

    assign load       = w_dec & ~ZMASK;
    assign w_wr_valid = |load;

    // Resolve one read address: range, zero word, bypass, then storage.
    function automatic logic [WIDTH-1:0] rd_val(
        input logic [ADDR_W-1:0] a
    );
        if ({1'b0, a} >= DEPTH_X) return '0;
        if (ZERO_REG && (a == '0)) return '0;
        if (BYPASS && w_wr_valid && (a == waddr)) return wdata;
        return r_mem[a];
    endfunction

    // Combinational read values presented to the output registers.
    always_comb begin
        w_val_a = rd_val(raddr_a);
        w_val_b = rd_val(raddr_b);
    end

    // Storage update: reset clears all words and wins over a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (load[i]) r_mem[i] <= wdata;
            end
        end
    end

    // Registered read ports with one cycle of latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            rdata_a <= w_val_a;
            rdata_b <= w_val_b;
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Randomised bench for regfile_2r1w across three configurations.
// Each cycle checks load strobes and registered reads against a model.
module tb_regfile_2r1w;

    logic        clk;
    logic        reset;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;

    logic [15:0] ra0, rb0, ra1, rb1;
    logic        ra2, rb2;
    logic [7:0]  load0;
    logic [5:0]  load1;
    logic [1:0]  load2;

    int n_chk  = 0;
    int n_pass = 0;

    int          DEP [3] = '{8, 6, 2};
    bit          BP  [3] = '{1'b1, 1'b0, 1'b1};
    bit          ZR  [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] MSK [3] = '{16'hFFFF, 16'hFFFF, 16'h0001};
    logic [15:0] mem [3][8];

    logic [63:0] g_load [3];
    logic [63:0] g_ra   [3];
    logic [63:0] g_rb   [3];

    regfile_2r1w #(
        .DEPTH(8), .WIDTH(16), .BYPASS(1'b1), .ZERO_REG(1'b0)
    ) u0 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(ra0), .rdata_b(rb0), .load(load0)
    );

    regfile_2r1w #(
        .DEPTH(6), .WIDTH(16), .BYPASS(1'b0), .ZERO_REG(1'b1)
    ) u1 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(ra1), .rdata_b(rb1), .load(load1)
    );

    regfile_2r1w #(
        .DEPTH(2), .WIDTH(1), .BYPASS(1'b1), .ZERO_REG(1'b0)
    ) u2 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr[0]),
        .wdata(wdata[0]), .raddr_a(raddr_a[0]), .raddr_b(raddr_b[0]),
        .rdata_a(ra2), .rdata_b(rb2), .load(load2)
    );

    assign g_load[0] = 64'(load0);
    assign g_load[1] = 64'(load1);
    assign g_load[2] = 64'(load2);
    assign g_ra[0]   = 64'(ra0);
    assign g_ra[1]   = 64'(ra1);
    assign g_ra[2]   = 64'(ra2);
    assign g_rb[0]   = 64'(rb0);
    assign g_rb[1]   = 64'(rb1);
    assign g_rb[2]   = 64'(rb2);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic int fold(int k, int a);
        return (k == 2) ? (a & 1) : a;
    endfunction

    function automatic bit wvalid(int k, bit w, int wa);
        return w && (wa < DEP[k]) && !(ZR[k] && wa == 0);
    endfunction

    function automatic logic [15:0] mval(int k, int a, bit w, int wa,
                                         logic [15:0] wd);
        if (a >= DEP[k]) return 16'h0;
        if (ZR[k] && a == 0) return 16'h0;
        if (BP[k] && wvalid(k, w, wa) && a == wa) return wd & MSK[k];
        return mem[k][a];
    endfunction

    task automatic cycle(input bit rst, input bit w, input int wa,
                         input logic [15:0] wd, input int a, input int b);
        logic [15:0] ea [3];
        logic [15:0] eb [3];
        logic [63:0] el;
        int          wk;
        reset   = rst;
        we      = w;
        waddr   = 3'(wa);
        wdata   = wd;
        raddr_a = 3'(a);
        raddr_b = 3'(b);
        #1;
        for (int k = 0; k < 3; k++) begin
            wk = fold(k, wa);
            el = wvalid(k, w, wk) ? (64'd1 << wk) : 64'd0;
            chk($sformatf("u%0d_load", k), g_load[k], el);
            ea[k] = rst ? 16'h0 : mval(k, fold(k, a), w, wk, wd);
            eb[k] = rst ? 16'h0 : mval(k, fold(k, b), w, wk, wd);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            wk = fold(k, wa);
            chk($sformatf("u%0d_rdata_a@%0d", k, a), g_ra[k], 64'(ea[k]));
            chk($sformatf("u%0d_rdata_b@%0d", k, b), g_rb[k], 64'(eb[k]));
            if (rst) begin
                for (int i = 0; i < 8; i++) mem[k][i] = 16'h0;
            end else if (wvalid(k, w, wk)) begin
                mem[k][wk] = wd & MSK[k];
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 8; i++) mem[k][i] = 16'h0;

        cycle(1, 1, 3, 16'hFFFF, 3, 3);
        cycle(1, 1, 3, 16'hFFFF, 3, 3);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 16'h0, i, 7 - i);

        cycle(0, 1, 5, 16'h1234, 0, 1);
        cycle(0, 0, 0, 16'h0, 5, 5);

        for (int i = 0; i < 8; i++) cycle(0, 1, i, 16'hA000 + 16'(i), 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 16'h0, i, 7 - i);

        cycle(0, 1, 2, 16'h0011, 0, 0);
        cycle(0, 1, 2, 16'h00FF, 2, 2);
        cycle(0, 0, 0, 16'h0, 2, 2);

        cycle(0, 1, 0, 16'hBEEF, 0, 0);
        cycle(0, 0, 0, 16'h0, 0, 0);

        cycle(0, 1, 6, 16'h5555, 7, 6);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 16'h0, i, 7);

        for (int i = 0; i < 8; i++)
            cycle(i == 5, 1, 1, 16'(i & 1), 1, 1);

        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(31) == 0, $urandom_range(3) != 0,
                  $urandom_range(7), 16'($urandom),
                  $urandom_range(7), $urandom_range(7));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
